multi_channel_debouncer: RTL and testbench
==========================================

Name: multi_channel_debouncer

Overview:
- Parametrised successor to the single-channel synchroniser-plus-counter debouncer.
- Debounces NUM_CH independent asynchronous inputs, each through its own synchroniser chain and stability counter.
- Adds a run-time stability threshold, per-channel enable, a configurable reset level, and registered one-cycle rise/fall event pulses.
- Sits between raw board inputs (buttons, switches) and control logic that consumes clean levels or edge events.

Parameters:
- NUM_CH, 4: number of independent channels; must be >= 1.
- SYNC_STAGES, 2: flip-flops per synchroniser chain; must be >= 2.
- CNT_W, 8: width of the threshold port and of each per-channel counter.
- RESET_LEVEL, 1'b0: value loaded into every synchroniser flop and every debounced output at reset.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- noisy_in  in  NUM_CH  raw asynchronous inputs; bit i belongs to channel i.
- threshold  in  CNT_W  required number of consecutive differing synchronised samples; 0 is treated as 1; sampled every cycle.
- ch_en  in  NUM_CH  per-channel enable.
- debounced_out  out  NUM_CH  debounced levels.
- rise_pulse  out  NUM_CH  one-cycle pulse when debounced_out[i] goes 0->1.
- fall_pulse  out  NUM_CH  one-cycle pulse when debounced_out[i] goes 1->0.
- any_event  out  1  OR of all rise_pulse and fall_pulse bits.

Behaviour:
- Reset (rst=1 at an edge):
  - all synchroniser flops and debounced_out <= RESET_LEVEL.
  - counters <= 0.
  - rise_pulse, fall_pulse <= 0; any_event therefore 0.
  - rst has priority over everything; a reset mid-count discards the count and emits no pulse.
- Synchroniser:
  - s[i] is the last flop of a SYNC_STAGES-deep chain clocked every cycle, independent of ch_en.
- Per-channel state machine, evaluated each edge when not in reset. Let T = max(threshold, 1).
  - ch_en[i]=0: cnt <= 0; debounced_out[i] holds; pulses 0.
  - s[i]==debounced_out[i]: cnt <= 0 (any agreeing sample restarts qualification); pulses 0.
  - s[i]!=debounced_out[i] and cnt < T-1: cnt <= cnt+1; pulses 0.
  - s[i]!=debounced_out[i] and cnt >= T-1: debounced_out[i] <= s[i]; cnt <= 0; rise_pulse[i] <= s[i]; fall_pulse[i] <= ~s[i].
- Pulses are registered and asserted in the same cycle debounced_out changes. They last exactly one cycle, because the next comparison agrees.
- Latency: an input step first sampled at edge 1 and held stable changes debounced_out at edge SYNC_STAGES+T, counting that sampling edge as edge 1. With defaults and T=5 this is edge 7.
- Threshold lowered mid-count: the >= compare means a count already at or above the new T-1 commits on the next differing edge. Raising the threshold simply extends qualification.
- Counter never exceeds 2^CNT_W-2, so there is no wrap-around. threshold=2^CNT_W-1 is legal.
- Channel disabled mid-count: count is lost. Re-enabling restarts qualification from 0.
- Channels are fully independent. Simultaneous events on several channels assert several pulse bits in the same cycle; any_event is 1 for that cycle.
- any_event is combinational OR of registered bits: no extra latency.

Test Plan:
- Reset level: RESET_LEVEL=0, rst=1 for 3 cycles with noisy_in=4'hF -> debounced_out=0, no pulses, any_event=0 throughout reset; release rst, hold 4'hF, threshold=5 -> debounced_out=4'hF and rise_pulse=4'hF for exactly one cycle, at the 7th edge after release.
- Glitch rejection: threshold=5; ch0 toggles 0/1/0/1 each cycle for 8 cycles, then holds 0 -> debounced_out[0] stays 0, no pulses. Then hold 1 for 4 synchronised cycles followed by one 0 -> no change. Then hold 1 -> rise_pulse[0] one cycle.
- Fall and threshold edge cases: ch1 high and debounced; threshold=0 -> after a 1->0 step, fall_pulse[1] occurs at edge SYNC_STAGES+1 = 3. Repeat with threshold=1 -> same timing.
- Threshold lowered mid-count: threshold=20; ch2 steps high; after cnt reaches 10, set threshold=4 -> commit on the next edge with rise_pulse[2]=1.
- Enable and simultaneity: ch_en=4'b1011, all inputs step high together -> channels 0, 1, 3 rise in the same cycle, rise_pulse=4'b1011, any_event=1 for one cycle, ch2 stays 0. Then set ch_en[2]=1 -> ch2 rises T cycles later.
- Reset mid-operation: ch3 counting toward a change, assert rst at cnt=3 -> next cycle debounced_out=RESET_LEVEL, no pulse; after release, qualification restarts from 0.

Source files
------------

// File: rtl/multi_channel_debouncer.sv
// rtl/multi_channel_debouncer.sv - NUM_CH independent synchroniser + stability-counter debouncers with edge pulses
module multi_channel_debouncer #(
  parameter int   NUM_CH      = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 8,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] noisy_in,
  input  logic [CNT_W-1:0]  threshold,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] debounced_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic              any_event
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] out_d;
  logic [NUM_CH-1:0] rise_d;
  logic [NUM_CH-1:0] fall_d;
  logic [CNT_W-1:0]  limit;

  // A threshold of 0 behaves as 1, so the commit limit (T-1) saturates at 0.
  assign limit = (threshold == '0) ? '0 : (threshold - CNT_ONE);
  assign s     = sync_q[SYNC_STAGES-1];

  // Synchroniser chains run every cycle regardless of channel enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= {NUM_CH{RESET_LEVEL}};
    end else begin
      sync_q[0] <= noisy_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Per-channel qualification: count consecutive disagreeing samples, commit at the limit.
  always_comb begin
    out_d  = debounced_out;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (ch_en[i] && (s[i] != debounced_out[i])) begin
        if (cnt_q[i] < limit) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else begin
          out_d[i]  = s[i];
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end
      end
    end
  end

  // State and pulse registers; reset discards any count in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      debounced_out <= {NUM_CH{RESET_LEVEL}};
      rise_pulse    <= '0;
      fall_pulse    <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      debounced_out <= out_d;
      rise_pulse    <= rise_d;
      fall_pulse    <= fall_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign any_event = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// tb/tb_multi_channel_debouncer.sv - self-checking bench for multi_channel_debouncer
module tb_multi_channel_debouncer;

  localparam int NCH = 4;
  localparam int SYN = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] noisy_in = '0;
  logic [7:0]     threshold = 8'd5;
  logic [NCH-1:0] ch_en = '1;
  logic [NCH-1:0] debounced_out, rise_pulse, fall_pulse;
  logic           any_event;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model: input delayed by SYN edges, run length of differing samples
  logic [NCH-1:0] hq[$];
  int             m_run [NCH];
  logic [NCH-1:0] m_out, m_rise, m_fall;
  logic           m_any;

  multi_channel_debouncer #(.NUM_CH(NCH), .SYNC_STAGES(SYN), .CNT_W(8), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .noisy_in(noisy_in), .threshold(threshold), .ch_en(ch_en),
    .debounced_out(debounced_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .any_event(any_event)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic [NCH-1:0] sv;
    int t;
    @(posedge clk);
    if (rst) begin
      hq.delete();
      for (int k = 0; k < SYN; k++) hq.push_back('0);
      m_out = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < NCH; i++) m_run[i] = 0;
    end else begin
      sv = hq.pop_front();
      hq.push_back(noisy_in);
      t = (threshold == 0) ? 1 : int'(threshold);
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < NCH; i++) begin
        if (!ch_en[i] || sv[i] == m_out[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] >= t) begin
            m_out[i] = sv[i]; m_rise[i] = sv[i]; m_fall[i] = ~sv[i]; m_run[i] = 0;
          end
        end
      end
    end
    m_any = |(m_rise | m_fall);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; noisy_in = 4'hF; threshold = 8'd5; ch_en = 4'hF;
    repeat (3) begin
      tick();
      tests_run++;
      if ({debounced_out, rise_pulse, fall_pulse, any_event} !== 13'b0) begin
        tests_failed++;
        $display("FAIL reset_state dut=%h exp=0", {debounced_out, rise_pulse, fall_pulse, any_event});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests_run++;
      if (debounced_out !== ((k >= 7) ? 4'hF : 4'h0) || rise_pulse !== ((k == 7) ? 4'hF : 4'h0) ||
          fall_pulse !== 4'h0 || any_event !== (k == 7)) begin
        tests_failed++;
        $display("FAIL reset_release edge=%0d out=%h rise=%h fall=%h any=%b", k, debounced_out, rise_pulse, fall_pulse, any_event);
      end
    end
  endtask

  task automatic test_glitch();
    threshold = 8'd5; noisy_in = 4'h0;
    settle(10);
    for (int k = 0; k < 20; k++) begin
      if (k < 8)       noisy_in[0] = k[0];
      else if (k < 12) noisy_in[0] = 1'b0;
      else if (k < 16) noisy_in[0] = 1'b1;
      else             noisy_in[0] = 1'b0;
      tick();
      tests_run++;
      if (debounced_out[0] !== 1'b0 || rise_pulse[0] !== 1'b0 || fall_pulse[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch_reject step=%0d out0=%b rise0=%b exp out0=0 rise0=0", k, debounced_out[0], rise_pulse[0]);
      end
    end
    noisy_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests_run++;
      if (rise_pulse[0] !== (k == 7) || debounced_out[0] !== (k >= 7)) begin
        tests_failed++;
        $display("FAIL glitch_commit edge=%0d rise0=%b out0=%b exp rise0=%b", k, rise_pulse[0], debounced_out[0], k == 7);
      end
    end
  endtask

  task automatic test_threshold_edges();
    for (int tv = 0; tv <= 1; tv++) begin
      threshold = 8'(tv); noisy_in[1] = 1'b1;
      settle(8);
      noisy_in[1] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        tick();
        tests_run++;
        if (fall_pulse[1] !== (k == 3) || debounced_out[1] !== (k < 3) || rise_pulse[1] !== 1'b0) begin
          tests_failed++;
          $display("FAIL thresh_%0d_fall edge=%0d fall1=%b out1=%b exp fall1=%b", tv, k, fall_pulse[1], debounced_out[1], k == 3);
        end
      end
    end
  endtask

  task automatic test_lower_mid();
    threshold = 8'd1; noisy_in = 4'h0;
    settle(6);
    threshold = 8'd20; noisy_in[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      tests_run++;
      if (rise_pulse[2] !== 1'b0 || debounced_out[2] !== 1'b0) begin
        tests_failed++;
        $display("FAIL lower_wait edge=%0d rise2=%b out2=%b exp 0", k, rise_pulse[2], debounced_out[2]);
      end
    end
    threshold = 8'd4;
    tick();
    tests_run++;
    if (rise_pulse[2] !== 1'b1 || debounced_out[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL lower_commit rise2=%b out2=%b exp 1", rise_pulse[2], debounced_out[2]);
    end
    tick();
    tests_run++;
    if (rise_pulse[2] !== 1'b0 || any_event !== 1'b0) begin
      tests_failed++;
      $display("FAIL lower_one_cycle rise2=%b any=%b exp 0", rise_pulse[2], any_event);
    end
  endtask

  task automatic test_enable();
    threshold = 8'd1; noisy_in = 4'h0; ch_en = 4'hF;
    settle(6);
    threshold = 8'd5; ch_en = 4'b1011; noisy_in = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests_run++;
      if (rise_pulse !== ((k == 7) ? 4'b1011 : 4'b0000) || any_event !== (k == 7) || debounced_out[2] !== 1'b0) begin
        tests_failed++;
        $display("FAIL enable_simul edge=%0d rise=%h any=%b out=%h", k, rise_pulse, any_event, debounced_out);
      end
    end
    ch_en = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests_run++;
      if (rise_pulse !== ((k == 5) ? 4'b0100 : 4'b0000) || debounced_out[2] !== (k >= 5)) begin
        tests_failed++;
        $display("FAIL enable_late edge=%0d rise=%h out=%h exp rise2=%b", k, rise_pulse, debounced_out, k == 5);
      end
    end
  endtask

  task automatic test_reset_mid();
    threshold = 8'd1; noisy_in = 4'h0;
    settle(6);
    threshold = 8'd5; noisy_in = 4'h8;
    settle(5);
    rst = 1'b1;
    tick();
    tests_run++;
    if ({debounced_out, rise_pulse, fall_pulse, any_event} !== 13'b0) begin
      tests_failed++;
      $display("FAIL reset_mid dut=%h exp=0", {debounced_out, rise_pulse, fall_pulse, any_event});
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests_run++;
      if (rise_pulse !== ((k == 7) ? 4'h8 : 4'h0) || debounced_out[3] !== (k >= 7)) begin
        tests_failed++;
        $display("FAIL reset_requal edge=%0d rise=%h out=%h exp rise3=%b", k, rise_pulse, debounced_out, k == 7);
      end
    end
  endtask

  task automatic test_max_threshold();
    threshold = 8'd1; noisy_in = 4'h0;
    settle(6);
    threshold = 8'd255; noisy_in = 4'h1;
    for (int k = 1; k <= 258; k++) begin
      tick();
      if (k >= 255) begin
        tests_run++;
        if (rise_pulse[0] !== (k == 257) || debounced_out[0] !== (k >= 257)) begin
          tests_failed++;
          $display("FAIL max_threshold edge=%0d rise0=%b out0=%b exp rise0=%b", k, rise_pulse[0], debounced_out[0], k == 257);
        end
      end
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(9) == 0)  noisy_in[i] = ~noisy_in[i];
        if ($urandom_range(79) == 0) ch_en[i] = ~ch_en[i];
      end
      if (c % 250 == 0) threshold = 8'($urandom_range(6));
      rst = ($urandom_range(499) == 0);
      tick();
      tests_run++;
      if ({debounced_out, rise_pulse, fall_pulse, any_event} !== {m_out, m_rise, m_fall, m_any}) begin
        tests_failed++;
        if (errs < 10)
          $display("FAIL random_model cycle=%0d dut=%h exp=%h", c, {debounced_out, rise_pulse, fall_pulse, any_event}, {m_out, m_rise, m_fall, m_any});
        errs++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_threshold_edges();
    test_lower_mid();
    test_enable();
    test_reset_mid();
    test_max_threshold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
